// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake.
// SKID_EN=1 adds a second (skid) entry so o_ready comes straight from a flop,
// cutting the combinational ready chain between neighbouring stages.
// SKID_EN=0 is a single register whose ready passes i_ready through.
// Flush empties the stage; with CLEAR_DATA=1 the storage is also set to BUBBLE_VAL.
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH      = 32,
   parameter bit               SKID_EN    = 1'b1,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter bit               CLEAR_DATA = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             pop;

   // Flush beats accept: data offered during a flush cycle is dropped.
   assign accept  = i_valid & o_ready & ~i_flush;
   assign pop     = o_valid & i_ready;
   assign o_valid = (state_q != EMPTY);
   assign o_data  = main_q;
   assign o_count = state_q;

   generate
      if (SKID_EN) begin : g_skid_ready
         logic ready_q;

         // Ready is a flop holding "next state is not FULL".
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (state_d != FULL);
            end
         end

         assign o_ready = ready_q;
      end else begin : g_pass_ready
         assign o_ready = ~o_valid | i_ready;
      end
   endgenerate

   // Next-state and storage update; main always holds the older entry.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (i_flush) begin
         state_d = EMPTY;
         if (CLEAR_DATA) begin
            main_d = BUBBLE_VAL;
            skid_d = BUBBLE_VAL;
         end
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = i_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = i_data;
               end else if (accept && SKID_EN) begin
                  state_d = FULL;
                  skid_d  = i_data;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and payload registers; reset drives the bubble onto o_data at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three configurations driven by shared stimulus,
// each checked against a FIFO-occupancy reference model.
//   dut0: SKID_EN=1, CLEAR_DATA=1, BUBBLE_VAL=32'h13
//   dut1: SKID_EN=0, CLEAR_DATA=1, BUBBLE_VAL=32'h13
//   dut2: SKID_EN=1, CLEAR_DATA=0, BUBBLE_VAL=32'hFFFF0000
module tb_pipe_stage_elastic;

   logic              clk;
   logic              rst_n;
   logic              i_flush;
   logic              i_valid;
   logic [31:0]       i_data;
   logic              i_ready;
   logic [2:0]        ov;
   logic [2:0]        ordy;
   logic [2:0][31:0]  od;
   logic [2:0][1:0]   oc;

   int checks = 0;
   int errors = 0;

   // Reference model: expected entries in arrival order, plus the value the
   // output shows while empty.
   logic [31:0] sb [3][64];
   int          rdp [3];
   int          wrp [3];
   int          cnt [3];
   logic [31:0] lastm [3];

   pipe_stage_elastic #(.WIDTH(32), .SKID_EN(1'b1), .BUBBLE_VAL(32'h13), .CLEAR_DATA(1'b1)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[0]),
      .i_data(i_data), .o_valid(ov[0]), .i_ready(i_ready), .o_data(od[0]), .o_count(oc[0]));

   pipe_stage_elastic #(.WIDTH(32), .SKID_EN(1'b0), .BUBBLE_VAL(32'h13), .CLEAR_DATA(1'b1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[1]),
      .i_data(i_data), .o_valid(ov[1]), .i_ready(i_ready), .o_data(od[1]), .o_count(oc[1]));

   pipe_stage_elastic #(.WIDTH(32), .SKID_EN(1'b1), .BUBBLE_VAL(32'hFFFF0000), .CLEAR_DATA(1'b0)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[2]),
      .i_data(i_data), .o_valid(ov[2]), .i_ready(i_ready), .o_data(od[2]), .o_count(oc[2]));

   function automatic bit cfg_skid(input int k);
      return (k != 1);
   endfunction

   function automatic bit cfg_clear(input int k);
      return (k != 2);
   endfunction

   function automatic logic [31:0] cfg_bubble(input int k);
      return (k == 2) ? 32'hFFFF0000 : 32'h00000013;
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %h required %h at %0t", name, k, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor + model: at the falling edge inputs and outputs are settled, so
   // compare outputs, then advance the model by the transfer at the next edge.
   initial begin
      logic [31:0] head;
      bit          mr, acc, pop;
      for (int k = 0; k < 3; k++) begin
         rdp[k] = 0; wrp[k] = 0; cnt[k] = 0; lastm[k] = cfg_bubble(k);
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               rdp[k] = 0; wrp[k] = 0; cnt[k] = 0; lastm[k] = cfg_bubble(k);
               chk("rst_valid", k, {31'd0, ov[k]}, 32'd0);
               chk("rst_count", k, {30'd0, oc[k]}, 32'd0);
               chk("rst_data", k, od[k], cfg_bubble(k));
            end else begin
               head = sb[k][rdp[k] & 63];
               mr   = cfg_skid(k) ? (cnt[k] < 2) : (cnt[k] == 0 || i_ready);
               chk("count", k, {30'd0, oc[k]}, cnt[k]);
               chk("valid", k, {31'd0, ov[k]}, {31'd0, cnt[k] != 0});
               chk("ready", k, {31'd0, ordy[k]}, {31'd0, mr});
               if (cnt[k] != 0) begin
                  chk("data", k, od[k], head);
                  lastm[k] = head;
               end else begin
                  chk("idle_data", k, od[k], lastm[k]);
               end
               acc = i_valid && mr && !i_flush;
               pop = (cnt[k] != 0) && i_ready;
               if (i_flush) begin
                  cnt[k] = 0;
                  rdp[k] = wrp[k];
                  if (cfg_clear(k)) lastm[k] = cfg_bubble(k);
               end else begin
                  if (pop) begin
                     rdp[k]++;
                     cnt[k]--;
                  end
                  if (acc) begin
                     sb[k][wrp[k] & 63] = i_data;
                     wrp[k]++;
                     cnt[k]++;
                  end
               end
            end
         end
      end
   end

   task automatic step(input bit v, input logic [31:0] d, input bit r, input bit f);
      i_valid = v;
      i_data  = d;
      i_ready = r;
      i_flush = f;
      @(posedge clk);
      #1;
   endtask

   // Stimulus: directed scenarios, then a randomized stream.
   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      i_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming at full rate.
      step(1, 32'h1, 1, 0);
      step(1, 32'h2, 1, 0);
      step(1, 32'h3, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);

      // Backpressure fills the skid entry, then drains in order.
      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      step(1, 32'hC, 0, 0);
      step(1, 32'hC, 1, 0);
      step(1, 32'hC, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);

      // Flush while full with new data offered.
      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      step(1, 32'hD, 0, 1);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);

      // Flush holding 0x55.
      step(1, 32'h55, 0, 0);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 1, 0);

      // Held entry, ready toggling, accept-and-pop replacement.
      step(1, 32'h7, 0, 0);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 1, 0);
      step(1, 32'h8, 0, 0);
      step(1, 32'h9, 1, 0);
      step(0, 32'h0, 1, 0);

      // Asynchronous reset while full.
      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_rst_valid", k, {31'd0, ov[k]}, 32'd0);
         chk("async_rst_data", k, od[k], cfg_bubble(k));
         chk("async_rst_count", k, {30'd0, oc[k]}, 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 32'h0, 1, 0);

      // Randomized stream.
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
      end
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);
      step(0, 32'h0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
